// File: rtl/raycast_pkg.sv
// Shared definitions for the ray-march path.
//   - default geometry and distance widths
//   - controller state encoding
//   - grid address packing {y, x}
//   - saturating unsigned add
package raycast_pkg;

    localparam int unsigned DEF_GRID_BITS = 6;
    localparam int unsigned DEF_DIST_W    = 16;
    localparam int unsigned DEF_MAX_STEPS = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStep  = 2'd1,
        StProbe = 2'd2,
        StDone  = 2'd3
    } state_t;

    // Packs a cell into a grid2D address. w is the per-coordinate width.
    function automatic logic [31:0] grid_addr(input logic [31:0] x, input logic [31:0] y,
                                              input int unsigned w);
        return (y << w) | x;
    endfunction

    // Unsigned a + b clamped to 2^w - 1. Operands must already fit in w bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            return lim[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/ray_dda_step.sv
// One DDA step, purely combinational.
//   i_cell_x/y, i_neg_x/y   : current cell and step directions
//   i_side_x/y, i_delta_x/y : running side distances and per-line increments
//   o_cell_x/y              : cell after the step (wraps mod 2^GRID_BITS)
//   o_side_x/y              : side distances after the step (saturating)
//   o_dist                  : side distance consumed by this step
//   o_side                  : 0 = x line crossed, 1 = y line crossed
module ray_dda_step
    import raycast_pkg::*;
#(
    parameter int unsigned GRID_BITS = DEF_GRID_BITS,
    parameter int unsigned DIST_W    = DEF_DIST_W
) (
    input  logic [GRID_BITS-1:0] i_cell_x,
    input  logic [GRID_BITS-1:0] i_cell_y,
    input  logic                 i_neg_x,
    input  logic                 i_neg_y,
    input  logic [DIST_W-1:0]    i_side_x,
    input  logic [DIST_W-1:0]    i_side_y,
    input  logic [DIST_W-1:0]    i_delta_x,
    input  logic [DIST_W-1:0]    i_delta_y,
    output logic [GRID_BITS-1:0] o_cell_x,
    output logic [GRID_BITS-1:0] o_cell_y,
    output logic [DIST_W-1:0]    o_side_x,
    output logic [DIST_W-1:0]    o_side_y,
    output logic [DIST_W-1:0]    o_dist,
    output logic                 o_side
);

    logic                 w_take_x;
    logic [GRID_BITS-1:0] w_nxt_x;
    logic [GRID_BITS-1:0] w_nxt_y;
    logic [DIST_W-1:0]    w_sum_x;
    logic [DIST_W-1:0]    w_sum_y;

    // Ties go to the x axis.
    assign w_take_x = (i_side_x <= i_side_y);

    assign w_nxt_x = i_neg_x ? (i_cell_x - GRID_BITS'(1)) : (i_cell_x + GRID_BITS'(1));
    assign w_nxt_y = i_neg_y ? (i_cell_y - GRID_BITS'(1)) : (i_cell_y + GRID_BITS'(1));

    assign w_sum_x = DIST_W'(sat_add(32'(i_side_x), 32'(i_delta_x), DIST_W));
    assign w_sum_y = DIST_W'(sat_add(32'(i_side_y), 32'(i_delta_y), DIST_W));

    always_comb begin
        o_cell_x = i_cell_x;
        o_cell_y = i_cell_y;
        o_side_x = i_side_x;
        o_side_y = i_side_y;
        o_dist   = i_side_x;
        o_side   = 1'b0;
        if (w_take_x) begin
            o_cell_x = w_nxt_x;
            o_side_x = w_sum_x;
        end else begin
            o_cell_y = w_nxt_y;
            o_side_y = w_sum_y;
            o_dist   = i_side_y;
            o_side   = 1'b1;
        end
    end

endmodule

// File: rtl/ray_march_ctrl.sv
// DDA ray-march controller: walks one ray across the grid, probing grid2D once per
// step, until a wall is found or MAX_STEPS probes have been made.
//   clk, resetn               : clock, asynchronous active-low reset
//   start + ray setup inputs  : start cell, step directions, initial/delta side distances
//   grid_address / grid_in    : registered {cell_y, cell_x} out, combinational wall bit in
//   busy, done                : busy from STEP through DONE; done is a one-cycle pulse
//   hit_*                     : result of the last probe, held until the next result
module ray_march_ctrl
    import raycast_pkg::*;
#(
    parameter int unsigned GRID_BITS = DEF_GRID_BITS,
    parameter int unsigned DIST_W    = DEF_DIST_W,
    parameter int unsigned MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [GRID_BITS-1:0]   start_cell_x,
    input  logic [GRID_BITS-1:0]   start_cell_y,
    input  logic                   step_x_neg,
    input  logic                   step_y_neg,
    input  logic [DIST_W-1:0]      side_dist_x0,
    input  logic [DIST_W-1:0]      side_dist_y0,
    input  logic [DIST_W-1:0]      delta_dist_x,
    input  logic [DIST_W-1:0]      delta_dist_y,
    output logic [2*GRID_BITS-1:0] grid_address,
    input  logic                   grid_in,
    output logic                   busy,
    output logic                   done,
    output logic                   hit_valid,
    output logic [GRID_BITS-1:0]   hit_x,
    output logic [GRID_BITS-1:0]   hit_y,
    output logic                   hit_side,
    output logic [DIST_W-1:0]      hit_dist
);

    localparam int unsigned CNT_W = $clog2(MAX_STEPS + 1);

    state_t r_state;
    state_t w_state_d;

    logic [GRID_BITS-1:0] r_cell_x;
    logic [GRID_BITS-1:0] r_cell_y;
    logic [DIST_W-1:0]    r_side_x;
    logic [DIST_W-1:0]    r_side_y;
    logic [DIST_W-1:0]    r_delta_x;
    logic [DIST_W-1:0]    r_delta_y;
    logic                 r_neg_x;
    logic                 r_neg_y;
    logic [CNT_W-1:0]     r_cnt;
    logic [DIST_W-1:0]    r_dist;
    logic                 r_side;

    logic                 r_hit_valid;
    logic [GRID_BITS-1:0] r_hit_x;
    logic [GRID_BITS-1:0] r_hit_y;
    logic                 r_hit_side;
    logic [DIST_W-1:0]    r_hit_dist;

    logic                 w_load;
    logic                 w_step;
    logic                 w_latch;
    logic [GRID_BITS-1:0] w_cell_x;
    logic [GRID_BITS-1:0] w_cell_y;
    logic [DIST_W-1:0]    w_side_x;
    logic [DIST_W-1:0]    w_side_y;
    logic [DIST_W-1:0]    w_dist;
    logic                 w_side;

    ray_dda_step #(
        .GRID_BITS (GRID_BITS),
        .DIST_W    (DIST_W)
    ) u_step (
        .i_cell_x  (r_cell_x),
        .i_cell_y  (r_cell_y),
        .i_neg_x   (r_neg_x),
        .i_neg_y   (r_neg_y),
        .i_side_x  (r_side_x),
        .i_side_y  (r_side_y),
        .i_delta_x (r_delta_x),
        .i_delta_y (r_delta_y),
        .o_cell_x  (w_cell_x),
        .o_cell_y  (w_cell_y),
        .o_side_x  (w_side_x),
        .o_side_y  (w_side_y),
        .o_dist    (w_dist),
        .o_side    (w_side)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_latch   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_d = StStep;
                end
            end
            StStep: begin
                w_step    = 1'b1;
                w_state_d = StProbe;
            end
            StProbe: begin
                // The counter already includes the step being probed now.
                if (grid_in || (r_cnt == CNT_W'(MAX_STEPS))) begin
                    w_latch   = 1'b1;
                    w_state_d = StDone;
                end else begin
                    w_state_d = StStep;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Ray walk registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cell_x  <= '0;
            r_cell_y  <= '0;
            r_side_x  <= '0;
            r_side_y  <= '0;
            r_delta_x <= '0;
            r_delta_y <= '0;
            r_neg_x   <= 1'b0;
            r_neg_y   <= 1'b0;
            r_cnt     <= '0;
            r_dist    <= '0;
            r_side    <= 1'b0;
        end else if (w_load) begin
            r_cell_x  <= start_cell_x;
            r_cell_y  <= start_cell_y;
            r_side_x  <= side_dist_x0;
            r_side_y  <= side_dist_y0;
            r_delta_x <= delta_dist_x;
            r_delta_y <= delta_dist_y;
            r_neg_x   <= step_x_neg;
            r_neg_y   <= step_y_neg;
            r_cnt     <= '0;
        end else if (w_step) begin
            r_cell_x  <= w_cell_x;
            r_cell_y  <= w_cell_y;
            r_side_x  <= w_side_x;
            r_side_y  <= w_side_y;
            r_dist    <= w_dist;
            r_side    <= w_side;
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers, updated only when a ray resolves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hit_valid <= 1'b0;
            r_hit_x     <= '0;
            r_hit_y     <= '0;
            r_hit_side  <= 1'b0;
            r_hit_dist  <= '0;
        end else if (w_latch) begin
            r_hit_valid <= grid_in;
            r_hit_x     <= r_cell_x;
            r_hit_y     <= r_cell_y;
            r_hit_side  <= r_side;
            r_hit_dist  <= r_dist;
        end
    end

    assign grid_address = (2*GRID_BITS)'(grid_addr(32'(r_cell_x), 32'(r_cell_y), GRID_BITS));
    assign busy         = (r_state != StIdle);
    assign done         = (r_state == StDone);
    assign hit_valid    = r_hit_valid;
    assign hit_x        = r_hit_x;
    assign hit_y        = r_hit_y;
    assign hit_side     = r_hit_side;
    assign hit_dist     = r_hit_dist;

endmodule

// File: tb/tb_ray_march_ctrl.sv
module tb_ray_march_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [5:0]  start_cell_x;
    logic [5:0]  start_cell_y;
    logic        step_x_neg;
    logic        step_y_neg;
    logic [15:0] side_dist_x0;
    logic [15:0] side_dist_y0;
    logic [15:0] delta_dist_x;
    logic [15:0] delta_dist_y;
    logic [11:0] grid_address;
    logic        grid_in;
    logic        busy;
    logic        done;
    logic        hit_valid;
    logic [5:0]  hit_x;
    logic [5:0]  hit_y;
    logic        hit_side;
    logic [15:0] hit_dist;

    int n_checks;
    int n_errors;

    // Hallway map: walls in columns 0 and 2 for rows 0..4, everything else open.
    assign grid_in = ((grid_address[5:0] == 6'd0) || (grid_address[5:0] == 6'd2)) &&
                     (grid_address[11:6] <= 6'd4);

    ray_march_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .start_cell_x (start_cell_x),
        .start_cell_y (start_cell_y),
        .step_x_neg   (step_x_neg),
        .step_y_neg   (step_y_neg),
        .side_dist_x0 (side_dist_x0),
        .side_dist_y0 (side_dist_y0),
        .delta_dist_x (delta_dist_x),
        .delta_dist_y (delta_dist_y),
        .grid_address (grid_address),
        .grid_in      (grid_in),
        .busy         (busy),
        .done         (done),
        .hit_valid    (hit_valid),
        .hit_x        (hit_x),
        .hit_y        (hit_y),
        .hit_side     (hit_side),
        .hit_dist     (hit_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one ray and observes it. start stays high for `hold` extra cycles while
    // busy. cyc is the cycle (after the start-sample edge) in which done was first
    // seen, -1 on timeout; ndone counts done pulses up to 8 cycles after that.
    task automatic run_ray(input logic [5:0] sx, input logic [5:0] sy,
                           input logic nx, input logic ny,
                           input logic [15:0] sdx, input logic [15:0] sdy,
                           input logic [15:0] ddx, input logic [15:0] ddy,
                           input int hold,
                           output int cyc, output int ndone, output logic hv,
                           output logic [5:0] hx, output logic [5:0] hy,
                           output logic hs, output logic [15:0] hd,
                           output logic [11:0] addr2, output logic busy1);
        @(negedge clk);
        start_cell_x = sx;
        start_cell_y = sy;
        step_x_neg   = nx;
        step_y_neg   = ny;
        side_dist_x0 = sdx;
        side_dist_y0 = sdy;
        delta_dist_x = ddx;
        delta_dist_y = ddy;
        start        = 1'b1;
        @(posedge clk);
        cyc   = -1;
        ndone = 0;
        hv    = 1'bx;
        hx    = 'x;
        hy    = 'x;
        hs    = 1'bx;
        hd    = 'x;
        addr2 = 'x;
        busy1 = 1'bx;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c > hold) start = 1'b0;
            if (c == 1) busy1 = busy;
            if (c == 2) addr2 = grid_address;
            if (done === 1'b1) begin
                ndone++;
                if (cyc < 0) begin
                    cyc = c;
                    hv  = hit_valid;
                    hx  = hit_x;
                    hy  = hit_y;
                    hs  = hit_side;
                    hd  = hit_dist;
                end
            end
            if (cyc >= 0 && c >= cyc + 8) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        start_cell_x = 6'd5;
        start_cell_y = 6'd7;
        step_x_neg   = 1'b0;
        step_y_neg   = 1'b0;
        side_dist_x0 = 16'h0;
        side_dist_y0 = 16'h0;
        delta_dist_x = 16'h0;
        delta_dist_y = 16'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, hit_valid, hit_x, hit_y, hit_side, hit_dist} !== 30'd0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b hv=%b x=%0d y=%0d s=%b d=%h want all 0",
                     busy, done, hit_valid, hit_x, hit_y, hit_side, hit_dist);
            n_errors++;
        end
        n_checks++;
        if (grid_address !== 12'd0) begin
            $display("FAIL reset_addr: got %h want 000", grid_address);
            n_errors++;
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle_no_start: got busy=%b done=%b want 0 0", busy, done);
            n_errors++;
        end
    endtask

    task automatic test_x_hit();
        int cyc, nd; logic hv, hs, b1; logic [5:0] hx, hy; logic [15:0] hd; logic [11:0] a2;
        // Scenario 1: +X from (1,2) into the wall at (2,2).
        run_ray(6'd1, 6'd2, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 0,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 3 || nd !== 1) begin
            $display("FAIL pos_x_timing: got cyc=%0d ndone=%0d want 3 1", cyc, nd);
            n_errors++;
        end
        n_checks++;
        if ({hv, hx, hy, hs, hd} !== {1'b1, 6'd2, 6'd2, 1'b0, 16'h0080}) begin
            $display("FAIL pos_x_result: got hv=%b (%0d,%0d) s=%b d=%h want 1 (2,2) 0 0080",
                     hv, hx, hy, hs, hd);
            n_errors++;
        end
        n_checks++;
        if (a2 !== 12'd130 || b1 !== 1'b1) begin
            $display("FAIL probe_addr_busy: got addr=%h busy=%b want 082 1", a2, b1);
            n_errors++;
        end
        // Scenario 2: -X from (1,2) into the wall at (0,2).
        run_ray(6'd1, 6'd2, 1'b1, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 0,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 3 || {hv, hx, hy, hs, hd} !== {1'b1, 6'd0, 6'd2, 1'b0, 16'h0080}) begin
            $display("FAIL neg_x: got cyc=%0d hv=%b (%0d,%0d) s=%b d=%h want 3 1 (0,2) 0 0080",
                     cyc, hv, hx, hy, hs, hd);
            n_errors++;
        end
        // X wraps 63 -> 0, landing on the wall in column 0.
        run_ray(6'd63, 6'd3, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 0,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 3 || {hv, hx, hy, hs, hd} !== {1'b1, 6'd0, 6'd3, 1'b0, 16'h0080}) begin
            $display("FAIL x_wrap: got cyc=%0d hv=%b (%0d,%0d) s=%b d=%h want 3 1 (0,3) 0 0080",
                     cyc, hv, hx, hy, hs, hd);
            n_errors++;
        end
    endtask

    task automatic test_y_then_x();
        int cyc, nd; logic hv, hs, b1; logic [5:0] hx, hy; logic [15:0] hd; logic [11:0] a2;
        // Scenario 3: Y to open (1,3), then X to wall (2,3).
        run_ray(6'd1, 6'd2, 1'b0, 1'b0, 16'h0080, 16'h0040, 16'h0100, 16'h0100, 0,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 5 || nd !== 1) begin
            $display("FAIL y_then_x_timing: got cyc=%0d ndone=%0d want 5 1", cyc, nd);
            n_errors++;
        end
        n_checks++;
        if ({hv, hx, hy, hs, hd} !== {1'b1, 6'd2, 6'd3, 1'b0, 16'h0080}) begin
            $display("FAIL y_then_x_result: got hv=%b (%0d,%0d) s=%b d=%h want 1 (2,3) 0 0080",
                     hv, hx, hy, hs, hd);
            n_errors++;
        end
    endtask

    task automatic test_miss();
        int cyc, nd; logic hv, hs, b1; logic [5:0] hx, hy; logic [15:0] hd; logic [11:0] a2;
        // Scenario 4: +Y along open column 1, wrapping the row; 64 probes, no wall.
        // Last step consumes 0x0080 + 63*0x0100 = 0x3F80.
        run_ray(6'd1, 6'd2, 1'b0, 1'b0, 16'hFFFF, 16'h0080, 16'hFFFF, 16'h0100, 0,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 129 || nd !== 1) begin
            $display("FAIL miss_timing: got cyc=%0d ndone=%0d want 129 1", cyc, nd);
            n_errors++;
        end
        n_checks++;
        if ({hv, hx, hy, hs, hd} !== {1'b0, 6'd1, 6'd2, 1'b1, 16'h3F80}) begin
            $display("FAIL miss_result: got hv=%b (%0d,%0d) s=%b d=%h want 0 (1,2) 1 3F80",
                     hv, hx, hy, hs, hd);
            n_errors++;
        end
    endtask

    task automatic test_saturation();
        int cyc, nd; logic hv, hs, b1; logic [5:0] hx, hy; logic [15:0] hd; logic [11:0] a2;
        // side_y 0x8000 + 0x8000 clamps to 0xFFFF, which ties with side_x so X goes next.
        run_ray(6'd1, 6'd3, 1'b0, 1'b0, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 0,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 5 || {hv, hx, hy, hs, hd} !== {1'b1, 6'd2, 6'd4, 1'b0, 16'hFFFF}) begin
            $display("FAIL saturate: got cyc=%0d hv=%b (%0d,%0d) s=%b d=%h want 5 1 (2,4) 0 FFFF",
                     cyc, hv, hx, hy, hs, hd);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc, nd; logic hv, hs, b1; logic [5:0] hx, hy; logic [15:0] hd; logic [11:0] a2;
        // Scenario 5: tie goes to X; start held through two busy cycles is ignored.
        run_ray(6'd1, 6'd2, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 2,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 3 || nd !== 1) begin
            $display("FAIL busy_start: got cyc=%0d ndone=%0d want 3 1", cyc, nd);
            n_errors++;
        end
        n_checks++;
        if ({hv, hx, hy, hs, hd} !== {1'b1, 6'd2, 6'd2, 1'b0, 16'h0100}) begin
            $display("FAIL tie_x: got hv=%b (%0d,%0d) s=%b d=%h want 1 (2,2) 0 0100",
                     hv, hx, hy, hs, hd);
            n_errors++;
        end
    endtask

    task automatic test_reset_mid_ray();
        int cyc, nd, seen; logic hv, hs, b1; logic [5:0] hx, hy; logic [15:0] hd; logic [11:0] a2;
        // Scenario 4 setup, reset asserted while in PROBE (even cycle).
        @(negedge clk);
        start_cell_x = 6'd1;
        start_cell_y = 6'd2;
        step_x_neg   = 1'b0;
        step_y_neg   = 1'b0;
        side_dist_x0 = 16'hFFFF;
        side_dist_y0 = 16'h0080;
        delta_dist_x = 16'hFFFF;
        delta_dist_y = 16'h0100;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || hit_valid !== 1'b1) begin
            $display("FAIL pre_reset_state: got busy=%b hv=%b want 1 1", busy, hit_valid);
            n_errors++;
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, hit_valid, hit_x, hit_y, hit_side, hit_dist, grid_address} !== 42'd0)
        begin
            $display("FAIL mid_reset_clear: got busy=%b done=%b hv=%b (%0d,%0d) s=%b d=%h a=%h want 0",
                     busy, done, hit_valid, hit_x, hit_y, hit_side, hit_dist, grid_address);
            n_errors++;
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            $display("FAIL mid_reset_no_done: got %0d done pulses want 0", seen);
            n_errors++;
        end
        run_ray(6'd1, 6'd2, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 0,
                cyc, nd, hv, hx, hy, hs, hd, a2, b1);
        n_checks++;
        if (cyc !== 3 || nd !== 1 ||
            {hv, hx, hy, hs, hd} !== {1'b1, 6'd2, 6'd2, 1'b0, 16'h0080}) begin
            $display("FAIL after_reset_ray: got cyc=%0d nd=%0d hv=%b (%0d,%0d) s=%b d=%h want 3 1 1 (2,2) 0 0080",
                     cyc, nd, hv, hx, hy, hs, hd);
            n_errors++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_x_hit();
        test_y_then_x();
        test_miss();
        test_saturation();
        test_back_to_back();
        test_reset_mid_ray();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
